// File: rtl/axis_burst_reader_pkg.sv
// Shared definitions for the packet burst reader and its stream register.
package axis_burst_reader_pkg;

  // Width of the FIFO read-side fill level.
  localparam int FIFO_CNT_W = 16;

  // Reader FSM states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register: holds data/last while downstream stalls
// and accepts a new word whenever the slot is empty or being drained.
module axis_reg_slice
  import axis_burst_reader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  input  logic              i_ready
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;

  // Slot is free when empty or when the held word leaves this cycle.
  assign o_ready = ~r_valid | i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

  // Load on upstream handshake; otherwise clear valid once downstream takes the word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_valid && o_ready) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_burst_reader.sv
// Drains a FIFO in fixed-length packets. A packet starts only once the FIFO
// already holds all of its words, so a burst never waits on missing data
// (unless the FIFO under-runs, in which case the burst simply pauses).
module axis_burst_reader
  import axis_burst_reader_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_enable,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic [FIFO_CNT_W-1:0]       fifo_count,
  output logic                        busy,
  output logic [31:0]                 sts_packets,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  state_t                r_state;
  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [CNTR_WIDTH-1:0] r_len;
  logic [31:0]           r_pkts;

  logic w_slot_free;
  logic w_rd;
  logic w_last;
  logic w_start;
  logic w_pkt_done;

  // Start only when the whole packet is already stored; zero length never starts.
  assign w_start    = cfg_enable && (cfg_length != '0) &&
                      (32'(fifo_count) >= 32'(cfg_length));
  assign s_axis_tready = (r_state == ST_BURST) && w_slot_free;
  assign w_rd       = s_axis_tready && s_axis_tvalid;
  assign w_last     = (r_cnt == (r_len - CNTR_WIDTH'(1)));
  assign w_pkt_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  assign busy        = (r_state == ST_BURST) || (m_axis_tvalid && m_axis_tlast);
  assign sts_packets = r_pkts;

  // Packet FSM: latch the length at start, count words, return to IDLE on the last read.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_BURST;
            r_len   <= cfg_length;
            r_cnt   <= '0;
          end
        end
        ST_BURST: begin
          if (w_rd) begin
            r_cnt <= r_cnt + CNTR_WIDTH'(1);
            if (w_last) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Completed-packet counter, wraps naturally at 2^32.
  always_ff @(posedge aclk) begin
    if (areset) r_pkts <= '0;
    else if (w_pkt_done) r_pkts <= r_pkts + 32'd1;
  end

  axis_reg_slice #(
    .DATA_W (AXIS_TDATA_WIDTH)
  ) u_out_reg (
    .aclk    (aclk),
    .areset  (areset),
    .i_data  (s_axis_tdata),
    .i_valid (w_rd),
    .i_last  (w_last),
    .o_ready (w_slot_free),
    .o_data  (m_axis_tdata),
    .o_valid (m_axis_tvalid),
    .o_last  (m_axis_tlast),
    .i_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_burst_reader.sv
// Bench for axis_burst_reader: FIFO emulation, scoreboard of expected packet
// words, and directed plus randomized packet scenarios.
module tb_axis_burst_reader;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cfg_enable = 1'b0;
  logic [CW-1:0] cfg_length = '0;
  logic [15:0]   fifo_count = '0;
  logic          busy;
  logic [31:0]   sts_packets;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;

  axis_burst_reader #(
    .AXIS_TDATA_WIDTH (DW),
    .CNTR_WIDTH       (CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_enable    (cfg_enable),
    .cfg_length    (cfg_length),
    .fifo_count    (fifo_count),
    .busy          (busy),
    .sts_packets   (sts_packets),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fifo_q[$];
  int            rd_cyc[$];
  int            rd_count = 0;
  int            cyc = 0;
  int            pk_total = 0;
  int            checks = 0;
  int            errors = 0;
  int            rdy_mode = 0;
  bit            tv_gate_en = 1'b0;
  bit            ovr_en = 1'b0;
  logic [15:0]   ovr_val = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    return e;
  endfunction

  // A packet of L random words: data into the FIFO, the same words expected out.
  task automatic push_pkt(input int len);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      fifo_q.push_back(d);
      exp_q.push_back(mk(d, i == len - 1));
    end
    pk_total++;
  endtask

  task automatic wait_reads(input int n);
    int t = 0;
    while (rd_count < n && t < 500) begin
      @(negedge aclk);
      t++;
    end
    if (rd_count < n) begin
      checks++;
      errors++;
      $display("FAIL wait_reads timeout actual=%0d required=%0d", rd_count, n);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout actual=%0d required=0 words pending", exp_q.size());
    end
    @(negedge aclk);
  endtask

  // FIFO model: pops on observed handshakes, presents head word and fill level.
  initial begin : fifo_drv
    bit hs;
    int rpat;
    rpat = 0;
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      if (hs && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        rd_count++;
        rd_cyc.push_back(cyc);
      end
      s_axis_tdata  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      s_axis_tvalid = (fifo_q.size() > 0) && (!tv_gate_en || ($urandom_range(0, 3) != 0));
      fifo_count    = ovr_en ? ovr_val : 16'(fifo_q.size());
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ((rpat % 4) == 0) || ((rpat % 4) == 3);
        default: m_axis_tready = ($urandom_range(0, 1) == 1);
      endcase
      rpat++;
    end
  end

  // Scoreboard monitor: every downstream handshake must match the next expected word.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!areset && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", 64'(m_axis_tdata), 64'(e.d));
          chk("m_tlast", 64'(m_axis_tlast), 64'(e.l));
        end
      end
    end
  end

  initial begin : main
    int  base;
    int  len;
    bit  seen;
    int  t;

    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 0);
    chk("rst_m_tdata", 64'(m_axis_tdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_sts", 64'(sts_packets), 0);
    chk("rst_s_tready", 64'(s_axis_tready), 0);

    // Threshold: 3 of 4 words stored must not start the packet.
    rdy_mode   = 0;
    cfg_length = 16'd4;
    cfg_enable = 1'b1;
    base = rd_count;
    for (int i = 1; i <= 4; i++) exp_q.push_back(mk(DW'(i), i == 4));
    for (int i = 1; i <= 3; i++) fifo_q.push_back(DW'(i));
    pk_total++;
    seen = 1'b0;
    repeat (20) begin
      @(negedge aclk);
      if (s_axis_tready) seen = 1'b1;
    end
    chk("thr_no_tready", 64'(seen), 0);
    chk("thr_no_read", 64'(rd_count), 64'(base));
    fifo_q.push_back(DW'(4));
    wait_reads(base + 1);
    chk("thr_busy", 64'(busy), 1);
    wait_drain();
    chk("thr_reads", 64'(rd_count - base), 4);
    if (rd_count - base == 4) chk("thr_span", 64'(rd_cyc[base + 3] - rd_cyc[base]), 3);
    chk("thr_pkts", 64'(sts_packets), 1);

    // Backpressure with a 1,0,0,1 ready pattern.
    rdy_mode   = 1;
    cfg_length = 16'd8;
    base = rd_count;
    push_pkt(8);
    wait_drain();
    chk("bp_reads", 64'(rd_count - base), 8);
    chk("bp_pkts", 64'(sts_packets), 64'(pk_total));

    // Zero length with a large fill level never starts.
    rdy_mode   = 0;
    cfg_length = '0;
    ovr_val    = 16'd100;
    ovr_en     = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge aclk);
      if (s_axis_tready || busy) seen = 1'b1;
    end
    chk("zero_len_idle", 64'(seen), 0);
    ovr_en = 1'b0;

    // Disabled: data present but no reads until enabled.
    cfg_enable = 1'b0;
    cfg_length = 16'd4;
    base = rd_count;
    push_pkt(4);
    repeat (20) @(negedge aclk);
    chk("dis_no_read", 64'(rd_count), 64'(base));
    cfg_enable = 1'b1;
    wait_drain();
    chk("dis_reads", 64'(rd_count - base), 4);
    chk("dis_pkts", 64'(sts_packets), 64'(pk_total));

    // Length change mid-burst is ignored; next packet uses the new length.
    cfg_length = 16'd6;
    base = rd_count;
    push_pkt(6);
    push_pkt(2);
    wait_reads(base + 1);
    cfg_length = 16'd2;
    wait_drain();
    chk("cfgchg_reads", 64'(rd_count - base), 8);
    chk("cfgchg_pkts", 64'(sts_packets), 64'(pk_total));

    // Back-to-back packets with one idle read cycle between them.
    cfg_length = 16'd3;
    base = rd_count;
    push_pkt(3);
    push_pkt(3);
    push_pkt(3);
    wait_drain();
    chk("b2b_reads", 64'(rd_count - base), 9);
    if (rd_count - base == 9) begin
      chk("b2b_span", 64'(rd_cyc[base + 8] - rd_cyc[base]), 10);
      chk("b2b_gap", 64'(rd_cyc[base + 3] - rd_cyc[base + 2]), 2);
    end
    chk("b2b_pkts", 64'(sts_packets), 64'(pk_total));

    // Reset after word 2 of a 5-word packet abandons it.
    cfg_length = 16'd5;
    base = rd_count;
    push_pkt(5);
    wait_reads(base + 2);
    areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    exp_q.delete();
    fifo_q.delete();
    pk_total = 0;
    chk("rstmid_m_tvalid", 64'(m_axis_tvalid), 0);
    chk("rstmid_busy", 64'(busy), 0);
    chk("rstmid_sts", 64'(sts_packets), 0);
    chk("rstmid_s_tready", 64'(s_axis_tready), 0);
    @(negedge aclk);
    base = rd_count;
    push_pkt(5);
    wait_drain();
    chk("rstmid_reads", 64'(rd_count - base), 5);
    chk("rstmid_pkts", 64'(sts_packets), 1);

    // Randomized lengths, ready and FIFO under-runs.
    rdy_mode   = 2;
    tv_gate_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      t = 0;
      while (fifo_q.size() != 0 && t < 500) begin
        @(negedge aclk);
        t++;
      end
      if (fifo_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL rand_fifo_wait actual=%0d required=0", fifo_q.size());
      end
      len = $urandom_range(1, 8);
      cfg_length = CW'(len);
      push_pkt(len);
    end
    wait_drain();
    chk("rand_fifo_empty", 64'(fifo_q.size()), 0);
    chk("rand_pkts", 64'(sts_packets), 64'(pk_total));
    tv_gate_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
